// File: rtl/reg27_arbiter_pkg.sv
// Shared definitions for the 27-bit register arbiter: state encoding and
// the storage width.
package reg27_arbiter_pkg;

  localparam int REG27_W = 27;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/gen_reg_27.sv
// Generic enabled storage register with asynchronous active-high clear.
module gen_reg_27
  import reg27_arbiter_pkg::*;
#(
  parameter int W = REG27_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg27_arbiter.sv
// Two-requester round-robin arbiter guarding one shared WIDTH-bit register,
// with a per-grant hold limit and a flag for writes attempted without a grant.
module reg27_arbiter
  import reg27_arbiter_pkg::*;
#(
  parameter int WIDTH     = REG27_W,
  parameter int MAX_HOLD  = 8,
  parameter bit RESET_PTR = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             req0,
  input  logic             wr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             req1,
  input  logic             wr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [WIDTH-1:0] rdata,
  output logic             wr_conflict,
  output logic [1:0]       dbg_state
);

  // Handshake: a requester raises reqX and keeps it high for as long as it
  // wants ownership; it owns the register in every cycle where gntX is high,
  // and a wrX strobe only counts in a cycle where gntX is also high.

  arb_state_t state;
  logic [7:0] hold_cnt;
  logic       ptr;
  logic       last_cycle;
  logic       reg_en;
  logic [WIDTH-1:0] reg_d;

  assign gnt0      = (state == GNT0);
  assign gnt1      = (state == GNT1);
  assign busy      = gnt0 | gnt1;
  assign dbg_state = state;

  assign last_cycle = (hold_cnt == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      ptr         <= RESET_PTR;
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= (wr0 & ~gnt0) | (wr1 & ~gnt1);
      case (state)
        IDLE: begin
          // Clearing here means every grant starts with a fresh count.
          hold_cnt <= '0;
          if (req0 && req1) begin
            state <= ptr ? GNT1 : GNT0;
          end else if (req0) begin
            state <= GNT0;
          end else if (req1) begin
            state <= GNT1;
          end
        end
        GNT0: begin
          if (!req0 || last_cycle) begin
            state <= IDLE;
            ptr   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        GNT1: begin
          if (!req1 || last_cycle) begin
            state <= IDLE;
            ptr   <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grants are one-hot, so selecting data by gnt1 alone is sufficient.
  assign reg_en = (gnt0 & wr0) | (gnt1 & wr1);
  assign reg_d  = gnt1 ? wdata1 : wdata0;

  gen_reg_27 #(
    .W (WIDTH)
  ) u_store (
    .clk (clk),
    .clr (~clr_n),
    .en  (reg_en),
    .d   (reg_d),
    .q   (rdata)
  );

endmodule

// File: tb/tb_reg27_arbiter.sv
// Bench for reg27_arbiter: directed vector table, hand-written reset and
// forced-release sequences, and random traffic against an ownership model.
module tb_reg27_arbiter;

  localparam int W        = 27;
  localparam int MAX_HOLD = 8;

  logic         clk;
  logic         clr_n;
  logic         req0, wr0, req1, wr1;
  logic [W-1:0] wdata0, wdata1;
  logic         gnt0, gnt1, busy, wr_conflict;
  logic [W-1:0] rdata;
  logic [1:0]   dbg_state;

  int unsigned vectors;
  int unsigned miscompares;

  // Reference model: who owns the register, how many cycles it has held it,
  // who gets priority on a tie, and what the register holds.
  int           m_owner;
  int           m_run;
  int           m_prio;
  logic [W-1:0] m_reg;
  logic         m_conf;
  logic [W-1:0] exp_q[$];

  reg27_arbiter #(
    .WIDTH     (W),
    .MAX_HOLD  (MAX_HOLD),
    .RESET_PTR (1'b0)
  ) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .req0        (req0),
    .wr0         (wr0),
    .wdata0      (wdata0),
    .req1        (req1),
    .wr1         (wr1),
    .wdata1      (wdata1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .busy        (busy),
    .rdata       (rdata),
    .wr_conflict (wr_conflict),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_run   = 0;
    m_prio  = 0;
    m_reg   = '0;
    m_conf  = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic nconf;
    nconf = (wr0 && m_owner != 0) || (wr1 && m_owner != 1);
    if (m_owner == 0 && wr0) m_reg = wdata0;
    else if (m_owner == 1 && wr1) m_reg = wdata1;
    if (m_owner == -1) begin
      if (req0 && req1) m_owner = m_prio;
      else if (req0) m_owner = 0;
      else if (req1) m_owner = 1;
      m_run = 1;
    end else begin
      if ((m_owner == 0 && !req0) || (m_owner == 1 && !req1) || m_run == MAX_HOLD) begin
        m_prio  = 1 - m_owner;
        m_owner = -1;
      end else begin
        m_run++;
      end
    end
    m_conf = nconf;
    exp_q.push_back(m_reg);
  endtask

  task automatic model_check();
    logic [W-1:0] exp_rd;
    logic [1:0]   exp_st;
    exp_rd = exp_q.pop_front();
    exp_st = (m_owner == -1) ? 2'b00 : (m_owner == 0) ? 2'b01 : 2'b10;
    chk("gnt0", 32'(gnt0), 32'(m_owner == 0));
    chk("gnt1", 32'(gnt1), 32'(m_owner == 1));
    chk("busy", 32'(busy), 32'(m_owner != -1));
    chk("rdata", 32'(rdata), 32'(exp_rd));
    chk("wr_conflict", 32'(wr_conflict), 32'(m_conf));
    chk("dbg_state", 32'(dbg_state), 32'(exp_st));
  endtask

  // Driver: apply inputs, let one edge pass, check one time unit later.
  task automatic step(input logic r0, input logic w0, input logic [W-1:0] d0,
                      input logic r1, input logic w1, input logic [W-1:0] d1);
    req0 = r0; wr0 = w0; wdata0 = d0;
    req1 = r1; wr1 = w1; wdata1 = d1;
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  typedef struct {
    logic         r0, w0;
    logic [W-1:0] d0;
    logic         r1, w1;
    logic [W-1:0] d1;
    logic         eg0, eg1;
    logic [W-1:0] erd;
    logic         ec;
  } vec_t;

  vec_t tbl[14];

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();

    tbl[0]  = '{1'b0, 1'b0, 27'h0,       1'b1, 1'b1, 27'h5A5A5A5, 1'b0, 1'b1, 27'h0,       1'b1};
    tbl[1]  = '{1'b0, 1'b0, 27'h0,       1'b1, 1'b1, 27'h5A5A5A5, 1'b0, 1'b1, 27'h5A5A5A5, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 27'h0,       1'b0, 1'b0, 27'h0,       1'b0, 1'b0, 27'h5A5A5A5, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 27'h0,       1'b1, 1'b0, 27'h0,       1'b1, 1'b0, 27'h5A5A5A5, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 27'h0,       1'b1, 1'b0, 27'h0,       1'b1, 1'b0, 27'h5A5A5A5, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 27'h0,       1'b1, 1'b0, 27'h0,       1'b1, 1'b0, 27'h5A5A5A5, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 27'h0,       1'b1, 1'b0, 27'h0,       1'b0, 1'b0, 27'h5A5A5A5, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 27'h0,       1'b1, 1'b0, 27'h0,       1'b0, 1'b1, 27'h5A5A5A5, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 27'h0,       1'b0, 1'b0, 27'h0,       1'b0, 1'b0, 27'h5A5A5A5, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 27'h0,       1'b0, 1'b0, 27'h0,       1'b1, 1'b0, 27'h5A5A5A5, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 27'h0,       1'b0, 1'b1, 27'h7FFFFFF, 1'b1, 1'b0, 27'h5A5A5A5, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 27'h0,       1'b0, 1'b0, 27'h0,       1'b1, 1'b0, 27'h5A5A5A5, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 27'h0123456, 1'b0, 1'b0, 27'h0,       1'b1, 1'b0, 27'h0123456, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 27'h0,       1'b0, 1'b0, 27'h0,       1'b0, 1'b0, 27'h0123456, 1'b0};

    // Reset held for two cycles while both requesters are asking
    clr_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0; wdata0 = '0; wdata1 = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_gnt1", 32'(gnt1), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_conf", 32'(wr_conflict), 32'd0);
    end
    clr_n = 1'b1;
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    chk("post_rst_gnt0", 32'(gnt0), 32'd1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

    // Directed table: single requester, round-robin, illegal write
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r0, tbl[i].w0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].d1);
      chk($sformatf("tbl%0d_gnt0", i), 32'(gnt0), 32'(tbl[i].eg0));
      chk($sformatf("tbl%0d_gnt1", i), 32'(gnt1), 32'(tbl[i].eg1));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].eg0 | tbl[i].eg1));
      chk($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(tbl[i].erd));
      chk($sformatf("tbl%0d_conf", i), 32'(wr_conflict), 32'(tbl[i].ec));
    end

    // Forced release with both held; priority currently with requester 1.
    // Each requester writes in its last granted cycle.
    for (int k = 1; k <= 36; k++) begin
      int           p;
      int           own;
      logic [W-1:0] d;
      logic         lw0, lw1;
      p   = (k - 1) % 9;
      own = (((k - 1) / 9) % 2 == 0) ? 1 : 0;
      d   = W'($urandom);
      lw0 = (p == 8) && (own == 0);
      lw1 = (p == 8) && (own == 1);
      step(1'b1, lw0, d, 1'b1, lw1, d);
      chk($sformatf("hold%0d_gnt0", k), 32'(gnt0), 32'(p < 8 && own == 0));
      chk($sformatf("hold%0d_gnt1", k), 32'(gnt1), 32'(p < 8 && own == 1));
      chk($sformatf("hold%0d_busy", k), 32'(busy), 32'(p < 8));
      if (p == 8) chk($sformatf("hold%0d_lastwr", k), 32'(rdata), 32'(d));
    end

    // Async reset in the middle of a GNT1 cycle with a write pending
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    chk("pre_arst_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b1; wr1 = 1'b1; wdata1 = 27'h3ABCDEF;
    #3;
    clr_n = 1'b0;
    #1;
    chk("arst_gnt1", 32'(gnt1), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rdata", 32'(rdata), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_nowrite", 32'(rdata), 32'd0);
    clr_n = 1'b1;
    model_reset();
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    chk("arst_ptr0", 32'(gnt0), 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, W'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
